// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: one 128-bit block (4 words) per line, refilled on a miss.
// Latency: a hit returns the word in the same cycle; a miss costs the miss cycle + FETCH cycles + one UPDATE.
// Backpressure: busywait stalls the fetch port during a miss; mem_busywait holds the cache in FETCH.
module icache_direct #(
  parameter int INDEX_W = 3,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic              busywait,
  output logic              mem_read,
  output logic [ADDR_W-5:0] mem_address,
  input  logic [127:0]      mem_readdata,
  input  logic              mem_busywait
);

  localparam int TAG_W = ADDR_W - 4 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int BLK_W = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

  state_t             state, state_nxt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [127:0]       data_arr [LINES];
  logic [BLK_W-1:0]   mreg;
  logic [127:0]       line_buf;
  logic               fetch_first;

  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [1:0]         pc_word;
  logic [127:0]       line_sel;
  logic               line_valid;
  logic               hit;
  logic [INDEX_W-1:0] mreg_index;
  logic [TAG_W-1:0]   mreg_tag;
  logic               load_miss;
  logic               capture;
  logic               install;
  logic               unused_pc;

  assign pc_index   = pc[INDEX_W+3:4];
  assign pc_tag     = pc[ADDR_W-1:INDEX_W+4];
  assign pc_word    = pc[3:2];
  assign unused_pc  = ^{pc[31:ADDR_W], pc[1:0]};
  assign line_sel   = data_arr[pc_index];
  assign line_valid = valid[pc_index];
  assign hit        = read & line_valid & (tag_arr[pc_index] == pc_tag);

  // Invalid lines read as zero so stale data never leaks after reset.
  assign instruction = line_valid ? line_sel[{pc_word, 5'd0} +: 32] : 32'd0;

  assign mreg_index  = mreg[INDEX_W-1:0];
  assign mreg_tag    = mreg[BLK_W-1:INDEX_W];
  assign mem_address = mreg;

  always_comb begin
    state_nxt = state;
    busywait  = 1'b0;
    mem_read  = 1'b0;
    load_miss = 1'b0;
    capture   = 1'b0;
    install   = 1'b0;
    case (state)
      IDLE: begin
        busywait = read & ~hit;
        if (read & ~hit) begin
          load_miss = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        // The memory has not seen the request yet on the entry cycle.
        if (!fetch_first && !mem_busywait) begin
          capture   = 1'b1;
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        busywait  = 1'b1;
        install   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mreg        <= '0;
      fetch_first <= 1'b0;
      valid       <= '0;
    end else begin
      state       <= state_nxt;
      fetch_first <= load_miss;
      if (load_miss) mreg <= {pc_tag, pc_index};
      if (install) valid[mreg_index] <= 1'b1;
    end
  end

  // Data and tag arrays are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) line_buf <= mem_readdata;
    if (install) begin
      data_arr[mreg_index] <= line_buf;
      tag_arr[mreg_index]  <= mreg_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct: a line-level cache model plus a block memory responder, checked every cycle.
module tb_icache_direct;

  localparam int INDEX_W = 3;
  localparam int ADDR_W  = 10;
  localparam int LINES   = 8;
  localparam int BLK_W   = 6;
  localparam int TAG_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              read = 1'b0;
  logic [31:0]       pc = 32'd0;
  logic [31:0]       instruction;
  logic              busywait;
  logic              mem_read;
  logic [BLK_W-1:0]  mem_address;
  logic [127:0]      mem_readdata = '0;
  logic              mem_busywait = 1'b0;

  always #5 clk = ~clk;

  icache_direct #(.INDEX_W(INDEX_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read         (read),
    .pc           (pc),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // Memory image, indexed by block address {tag,index}.
  logic [127:0]     mem_blk [64];

  // Cache contents as the cpu should observe them.
  bit               mv [LINES];
  logic [TAG_W-1:0] mt [LINES];
  logic [127:0]     md [LINES];

  // Outstanding refill: cycles left until the cache is back in IDLE.
  int               rl = 0;
  int               fcyc = 0;
  int               lat = 0;
  int               next_lat = -1;
  logic [BLK_W-1:0] mreg = '0;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               bw_cycles = 0;
  int               mr_cycles = 0;
  logic             bw_last = 1'b0;
  logic             mr_last = 1'b0;
  logic [31:0]      ins_last = '0;
  logic [BLK_W-1:0] ma_last = '0;

  logic [2:0]       ci;
  logic [2:0]       ct;
  logic             ch;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bw_last  = busywait;
    mr_last  = mem_read;
    ins_last = instruction;
    ma_last  = mem_address;
    if (busywait) bw_cycles++;
    if (mem_read) mr_cycles++;
    if (rl > 0) begin
      check("refill_busywait", {31'd0, busywait}, 32'd1);
      check("refill_mem_read", {31'd0, mem_read}, {31'd0, rl > 1});
      check("refill_mem_address", {26'd0, mem_address}, {26'd0, mreg});
    end else begin
      ci = pc[6:4];
      ct = pc[9:7];
      ch = read && mv[ci] && (mt[ci] == ct);
      check("idle_busywait", {31'd0, busywait}, {31'd0, read && !ch});
      check("idle_mem_read", {31'd0, mem_read}, 32'd0);
      check("idle_mem_address", {26'd0, mem_address}, {26'd0, mreg});
      if (ch)
        check("hit_instruction", instruction, md[ci][{pc[3:2], 5'd0} +: 32]);
      else if (!mv[ci])
        check("invalid_instruction", instruction, 32'd0);
    end
  end

  task automatic model_step();
    logic [2:0] i;
    logic [2:0] t;
    if (!rst_n) return;
    if (rl > 0) begin
      rl--;
      if (rl == 0) begin
        mv[mreg[2:0]] = 1'b1;
        mt[mreg[2:0]] = mreg[5:3];
        md[mreg[2:0]] = mem_blk[mreg];
      end
    end else if (read) begin
      i = pc[6:4];
      t = pc[9:7];
      if (!(mv[i] && mt[i] == t)) begin
        mreg     = {t, i};
        lat      = (next_lat >= 0) ? next_lat : int'($urandom_range(0, 5));
        next_lat = -1;
        fcyc     = ((lat < 1) ? 1 : lat) + 1;
        rl       = fcyc + 1;
      end
    end
  endtask

  // Memory keeps mem_busywait high for the first lat FETCH cycles; data is valid only when it drops.
  task automatic cyc(input logic r, input logic [31:0] p);
    int idx;
    read         = r;
    pc           = p;
    mem_readdata = {$urandom, $urandom, $urandom, $urandom};
    mem_busywait = 1'($urandom);
    if (rl > 0) begin
      idx = fcyc + 1 - rl;
      if (idx < fcyc) begin
        mem_busywait = (idx < lat);
        if (idx >= 1 && idx >= lat) mem_readdata = mem_blk[mreg];
      end
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input int n, input logic r, input logic [31:0] p);
    rst_n = 1'b0;
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    rl   = 0;
    mreg = '0;
    #1;
    check("reset_mem_read", {31'd0, mem_read}, 32'd0);
    check("reset_mem_address", {26'd0, mem_address}, 32'd0);
    repeat (n) cyc(r, p);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input logic [31:0] p, input string nm);
    for (int k = 0; k < 60; k++) begin
      cyc(1'b1, p);
      if (!bw_last) break;
    end
    check(nm, {31'd0, bw_last}, 32'd0);
  endtask

  initial begin
    logic [31:0] p;
    logic [2:0]  tg;
    for (int b = 0; b < 64; b++) mem_blk[b] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[0] = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    mem_blk[1] = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    mem_blk[8] = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};

    repeat (3) cyc(1'b0, 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 32'd0);

    // Cold miss at 0x000, memory busy for 3 FETCH cycles.
    next_lat  = 3;
    bw_cycles = 0;
    mr_cycles = 0;
    cyc(1'b1, 32'h000);
    check("t1_miss_busywait", {31'd0, bw_last}, 32'd1);
    check("t1_miss_mem_read", {31'd0, mr_last}, 32'd0);
    cyc(1'b1, 32'h000);
    check("t1_fetch_mem_read", {31'd0, mr_last}, 32'd1);
    check("t1_fetch_addr", {26'd0, ma_last}, 32'h00);
    wait_idle(32'h000, "t1_refill_timeout");
    check("t1_busy_cycles", bw_cycles, 32'd6);
    check("t1_mem_read_cycles", mr_cycles, 32'd4);
    check("t1_word0", ins_last, 32'h1111_0000);

    for (int k = 1; k < 4; k++) begin
      cyc(1'b1, 32'(k * 4));
      check("t2_word", ins_last, 32'h1111_0000 + 32'(k));
      check("t2_no_stall", {31'd0, bw_last}, 32'd0);
      check("t2_no_mem_read", {31'd0, mr_last}, 32'd0);
    end

    // Conflicting tag on index 0 evicts the line.
    next_lat = 2;
    cyc(1'b1, 32'h080);
    cyc(1'b1, 32'h080);
    check("t3_addr", {26'd0, ma_last}, 32'h08);
    wait_idle(32'h080, "t3_refill_timeout");
    check("t3_word0", ins_last, 32'h2222_0000);
    cyc(1'b1, 32'h000);
    check("t3_evicted_miss", {31'd0, bw_last}, 32'd1);
    wait_idle(32'h000, "t3_refetch_timeout");
    check("t3_refetch_word0", ins_last, 32'h1111_0000);

    // PC wanders during the refill; the fill still targets block 0x01.
    next_lat = 4;
    cyc(1'b1, 32'h010);
    cyc(1'b1, 32'h010);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h3F0);
      check("t4_addr_held", {26'd0, ma_last}, 32'h01);
    end
    cyc(1'b1, 32'h3F0);
    check("t4_update_busy", {31'd0, bw_last}, 32'd1);
    cyc(1'b1, 32'h010);
    check("t4_hit_after", {31'd0, bw_last}, 32'd0);
    check("t4_word0", ins_last, 32'h3333_0000);

    // Reset in the middle of a FETCH.
    next_lat = 10;
    repeat (3) cyc(1'b1, 32'h100);
    check("t5_in_fetch", {31'd0, mr_last}, 32'd1);
    do_reset(2, 1'b1, 32'h000);
    cyc(1'b1, 32'h000);
    check("t5_miss_after_reset", {31'd0, bw_last}, 32'd1);
    wait_idle(32'h000, "t5_refill_timeout");
    check("t5_word0", ins_last, 32'h1111_0000);

    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, $urandom);
      check("t6_idle_busywait", {31'd0, bw_last}, 32'd0);
      check("t6_idle_mem_read", {31'd0, mr_last}, 32'd0);
    end
    cyc(1'b1, 32'h008);
    check("t6_still_hit", ins_last, 32'h1111_0002);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(int'($urandom_range(1, 3)), 1'($urandom), $urandom);
      end else begin
        tg = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
        p      = $urandom;
        p[9:7] = tg;
        p[6:4] = 3'($urandom_range(0, 7));
        cyc($urandom_range(0, 7) != 0, p);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
